gpio_irq_ctrl: RTL and testbench

Input-conditioning and interrupt stage downstream of the GPIO port block. Consumes the port's sampled input word and its direction word, registers and optionally debounces each input pin, and detects rising/falling edges per pin. Latches detected edges into a write-1-to-clear pending register and drives a single registered interrupt line to the CPU.

---
 rtl/gpio_irq_ctrl.sv | 134 +++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_irq_ctrl
//  Description : GPIO input conditioning and interrupt stage. Registers the
//                sampled pin word, filters each input pin (optionally with a
//                per-pin debounce counter), detects rising/falling edges,
//                latches them into a write-1-to-clear pending register and
//                drives one registered interrupt line.
//                Optional feature macro: GPIO_IRQ_DEBOUNCE_EN
//                (defined -> per-pin debounce of DB_CYCLES cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DB_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic [WIDTH-1:0] i_ddir,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_ien,
    input  logic [WIDTH-1:0] i_clr,
    input  logic             i_clr_we,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq
);

    logic [WIDTH-1:0] raw_q;
    logic [WIDTH-1:0] flt_q;
    logic [WIDTH-1:0] flt_d;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             prime_q;
    logic             armed_q;
    logic             irq_q;

    // Sample the pins and sequence arming. raw_q holds a genuine pin sample
    // only after the first edge, so the filter seeds straight from it for one
    // more edge; a pin held high through reset therefore never looks like an
    // edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            raw_q   <= '0;
            prime_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            raw_q   <= i_din;
            prime_q <= 1'b1;
            armed_q <= prime_q;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    // Debounce: an input pin takes a new level only after the sample has
    // disagreed with it for DB_CYCLES consecutive edges; output pins and the
    // unarmed pipeline follow the sample directly with the counter held at 0.
    always_comb begin
        flt_d = flt_q;
        for (int p = 0; p < WIDTH; p++) begin
            cnt_d[p] = '0;
            if (!armed_q || !i_ddir[p]) begin
                flt_d[p] = raw_q[p];
            end else if (raw_q[p] != flt_q[p]) begin
                if (cnt_q[p] == CNT_MAX) begin
                    flt_d[p] = raw_q[p];
                end else begin
                    cnt_d[p] = cnt_q[p] + CW'(1);
                end
            end
        end
    end

    // Debounce counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < WIDTH; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < WIDTH; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end
`else
    // The debounce length has no role when the filter is a plain register.
    logic [31:0] db_cycles_unused;
    assign db_cycles_unused = 32'(DB_CYCLES);

    // Without debounce the filter is a single register stage on every pin
    always_comb begin
        flt_d = raw_q;
    end
`endif

    // Edge events on armed input pins, then W1C pending with set winning
    always_comb begin
        evt = '0;
        if (armed_q) begin
            evt = i_ddir & (flt_d ^ flt_q) &
                  ((flt_d & i_rise_en) | (~flt_d & i_fall_en));
        end
        pending_d = (pending_q & ~(i_clr & {WIDTH{i_clr_we}})) | evt;
    end

    // Filtered level, pending and interrupt registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flt_q     <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            flt_q     <= flt_d;
            pending_q <= pending_d;
            irq_q     <= |(pending_q & i_ien);
        end
    end

    assign o_level   = flt_q;
    assign o_pending = pending_q;
    assign o_irq     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_irq_ctrl
//  Description : Self-checking bench for gpio_irq_ctrl. Directed scenarios
//                plus a randomized run against a behavioural pin model.
//                Follows GPIO_IRQ_DEBOUNCE_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_ctrl;

    localparam int W  = 32;
    localparam int DB = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int LAT = DB;
`else
    localparam int LAT = 1;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [W-1:0] i_din;
    logic [W-1:0] i_ddir;
    logic [W-1:0] i_rise_en;
    logic [W-1:0] i_fall_en;
    logic [W-1:0] i_ien;
    logic [W-1:0] i_clr;
    logic         i_clr_we;
    logic [W-1:0] o_level;
    logic [W-1:0] o_pending;
    logic         o_irq;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_irq_ctrl #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_din     (i_din),
        .i_ddir    (i_ddir),
        .i_rise_en (i_rise_en),
        .i_fall_en (i_fall_en),
        .i_ien     (i_ien),
        .i_clr     (i_clr),
        .i_clr_we  (i_clr_we),
        .o_level   (o_level),
        .o_pending (o_pending),
        .o_irq     (o_irq)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Behavioural model: a pin's level adopts its last sample once that
    // sample has disagreed with the level for LAT consecutive edges; the
    // change is an event if the matching edge enable is set.
    // ------------------------------------------------------------------
    logic [W-1:0] m_raw, m_lvl, m_pend;
    logic         m_irq;
    int           m_run [W];
    int           m_edges;
    logic [W-1:0] n_lvl, n_pend, n_evt;
    logic         n_irq;
    int           n_run [W];

    always_comb begin
        n_lvl = m_lvl;
        n_evt = '0;
        for (int p = 0; p < W; p++) begin
            n_run[p] = 0;
            if (m_edges < 2 || !i_ddir[p]) begin
                n_lvl[p] = m_raw[p];
            end else if (m_raw[p] != m_lvl[p]) begin
                if (m_run[p] + 1 >= LAT) begin
                    n_lvl[p] = m_raw[p];
                    n_evt[p] = m_raw[p] ? i_rise_en[p] : i_fall_en[p];
                end else begin
                    n_run[p] = m_run[p] + 1;
                end
            end
        end
        n_pend = (m_pend & ~(i_clr_we ? i_clr : '0)) | n_evt;
        n_irq  = |(m_pend & i_ien);
    end

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_raw   <= '0;
            m_lvl   <= '0;
            m_pend  <= '0;
            m_irq   <= 1'b0;
            m_edges <= 0;
            for (int p = 0; p < W; p++) m_run[p] <= 0;
        end else begin
            m_raw  <= i_din;
            m_lvl  <= n_lvl;
            m_pend <= n_pend;
            m_irq  <= n_irq;
            if (m_edges < 2) m_edges <= m_edges + 1;
            for (int p = 0; p < W; p++) m_run[p] <= n_run[p];
        end
    end

    // Clear every pending bit for one cycle
    task automatic clear_all();
        i_clr    = '1;
        i_clr_we = 1'b1;
        @(negedge i_clk);
        i_clr_we = 1'b0;
        i_clr    = '0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_din = '1; i_ddir = '1; i_rise_en = '1; i_fall_en = '0;
        i_ien = '1; i_clr = '0; i_clr_we = 1'b0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_level !== '0 || o_pending !== '0 || o_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got level=%h pend=%h irq=%b required all 0", o_level, o_pending, o_irq);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_level !== '1) begin
            n_fail++;
            $display("FAIL reset_level: got %h required ffffffff", o_level);
        end
        repeat (LAT + 3) begin
            n_checks++;
            if (o_pending !== '0 || o_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_event: got pend=%h irq=%b required 0/0", o_pending, o_irq);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_rise_irq();
        i_din = '0; i_rise_en = '0; i_fall_en = '0; i_ien = '0;
        repeat (LAT + 2) @(negedge i_clk);
        clear_all();
        i_rise_en = 32'h8; i_ien = 32'h8;
        i_din[3] = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_level !== m_lvl) begin
                n_fail++;
                $display("FAIL rise_level k=%0d: got %h required %h", k, o_level, m_lvl);
            end
            if (k == LAT - 1) begin
                n_checks++;
                if (o_pending !== '0) begin
                    n_fail++;
                    $display("FAIL rise_early: got %h required 0", o_pending);
                end
            end
            if (k == LAT) begin
                n_checks++;
                if (o_pending !== 32'h8 || o_irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rise_pending: got pend=%h irq=%b required 8/0", o_pending, o_irq);
                end
            end
            if (k == LAT + 1) begin
                n_checks++;
                if (o_irq !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rise_irq: got %b required 1", o_irq);
                end
            end
        end
    endtask

    task automatic test_glitch();
        clear_all();
        i_rise_en = 32'h1; i_fall_en = '0; i_ien = '0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
        // Pulse one cycle shorter than the debounce length
        i_din[0] = 1'b1;
        for (int k = 0; k <= 2 * DB + 1; k++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_level[0] !== 1'b0 || o_pending[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_short k=%0d: got level0=%b pend0=%b required 0/0", k, o_level[0], o_pending[0]);
            end
            if (k == DB - 2) i_din[0] = 1'b0;
        end
`endif
        // Pulse exactly as long as the filter latency
        i_din[0] = 1'b1;
        for (int k = 0; k <= 2 * LAT + 1; k++) begin
            @(negedge i_clk);
            if (k == LAT) begin
                n_checks++;
                if (o_level[0] !== 1'b1 || o_pending[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL glitch_long: got level0=%b pend0=%b required 1/1", o_level[0], o_pending[0]);
                end
            end
            if (k == LAT - 1) i_din[0] = 1'b0;
        end
        n_checks++;
        if (o_level[0] !== 1'b0 || o_pending !== 32'h1) begin
            n_fail++;
            $display("FAIL glitch_after: got level0=%b pend=%h required 0/00000001", o_level[0], o_pending);
        end
    endtask

    task automatic test_clear_setwins();
        clear_all();
        i_ien = 32'h20; i_rise_en = 32'h20; i_fall_en = '0;
        i_din[5] = 1'b1;
        repeat (LAT + 1) @(negedge i_clk);
        n_checks++;
        if (o_pending !== 32'h20) begin
            n_fail++;
            $display("FAIL clr_setup: got %h required 00000020", o_pending);
        end
        i_rise_en = '0; i_fall_en = 32'h20;
        i_din[5] = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge i_clk);
            if (k == LAT - 1) begin
                i_clr = 32'h20; i_clr_we = 1'b1;
            end
        end
        i_clr_we = 1'b0; i_clr = '0;
        n_checks++;
        if (o_pending !== 32'h20 || o_level[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_set_wins: got pend=%h level5=%b required 00000020/0", o_pending, o_level[5]);
        end
        i_clr = 32'h20; i_clr_we = 1'b1;
        @(negedge i_clk);
        i_clr_we = 1'b0; i_clr = '0;
        n_checks++;
        if (o_pending !== '0 || o_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_alone: got pend=%h irq=%b required 0/1", o_pending, o_irq);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_irq_drop: got %b required 0", o_irq);
        end
    endtask

    task automatic test_output_pin();
        logic prev;
        clear_all();
        i_ien = '1; i_rise_en = '1; i_fall_en = '1;
        i_ddir = ~32'h80;
        prev = i_din[7];
        for (int k = 0; k < 12; k++) begin
            i_din[7] = ~i_din[7];
            @(negedge i_clk);
            if (k >= 1) begin
                n_checks++;
                if (o_level[7] !== prev) begin
                    n_fail++;
                    $display("FAIL outpin_level k=%0d: got %b required %b", k, o_level[7], prev);
                end
            end
            n_checks++;
            if (o_pending !== '0 || o_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL outpin_event k=%0d: got pend=%h irq=%b required 0/0", k, o_pending, o_irq);
            end
            prev = i_din[7];
        end
        i_ddir = '1;
        repeat (LAT + 2) @(negedge i_clk);
    endtask

    task automatic test_ien_mask_reset();
        i_ien = '0; i_rise_en = 32'h4; i_fall_en = '0;
        clear_all();
        i_din[2] = 1'b1;
        repeat (LAT + 3) @(negedge i_clk);
        n_checks++;
        if (o_pending !== 32'h4 || o_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ien_masked: got pend=%h irq=%b required 00000004/0", o_pending, o_irq);
        end
        i_ien = 32'h4;
        @(negedge i_clk);
        n_checks++;
        if (o_irq !== 1'b1 || o_pending !== 32'h4) begin
            n_fail++;
            $display("FAIL ien_enable: got pend=%h irq=%b required 00000004/1", o_pending, o_irq);
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_irq !== 1'b0 || o_pending !== '0 || o_level !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got irq=%b pend=%h level=%h required 0", o_irq, o_pending, o_level);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_random();
        i_ddir = '1;
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_level !== m_lvl) begin
                n_fail++;
                $display("FAIL rand_level c=%0d: got %h required %h", c, o_level, m_lvl);
            end
            n_checks++;
            if (o_pending !== m_pend) begin
                n_fail++;
                $display("FAIL rand_pending c=%0d: got %h required %h", c, o_pending, m_pend);
            end
            n_checks++;
            if (o_irq !== m_irq) begin
                n_fail++;
                $display("FAIL rand_irq c=%0d: got %b required %b", c, o_irq, m_irq);
            end
            i_din = i_din ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) i_ddir = i_ddir ^ (32'h1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 15) == 0) i_rise_en = $urandom;
            if ($urandom_range(0, 15) == 0) i_fall_en = $urandom;
            if ($urandom_range(0, 7) == 0) i_ien = $urandom;
            i_clr    = $urandom;
            i_clr_we = ($urandom_range(0, 3) == 0);
        end
        i_clr_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_irq();
        test_glitch();
        test_clear_setwins();
        test_output_pin();
        test_ien_mask_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
